// File: rtl/can_rx_sequencer.sv
// ============================================================================
// Module   : can_rx_sequencer
// Summary  : CAN 2.0A frame-level receive sequencer: bus-idle detection,
//            destuffing, field tracking and synchronizer control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_rx_sequencer #(
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        sampleStrobe,
  input  logic        rxBit,
  input  logic        cfgMultiSample,
  output logic        override,
  output logic        multiSelect,
  output logic        bitValid,
  output logic        bitOut,
  output logic [2:0]  field,
  output logic [10:0] rxId,
  output logic        rxRtr,
  output logic [3:0]  rxDlc,
  output logic        frameDone,
  output logic        stuffErr,
  output logic        formErr
);

  // State encoding doubles as the externally visible field code.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_CTRL      = 3'd2,
    S_DATA      = 3'd3,
    S_CRC       = 3'd4,
    S_TAIL      = 3'd5,
    S_WAIT_IDLE = 3'd7
  } seqState_t;

  localparam logic [3:0] c_idleLast = 4'(IDLE_BITS - 1);
  localparam logic [2:0] c_stuffRun = 3'd5;

  seqState_t   r_state,     w_state;
  logic [6:0]  r_bitCnt,    w_bitCnt;
  logic [3:0]  r_idleCnt,   w_idleCnt;
  logic        r_lastBit,   w_lastBit;
  logic [2:0]  r_sameCnt,   w_sameCnt;
  logic        r_bitValid,  w_bitValid;
  logic        r_bitOut,    w_bitOut;
  logic [10:0] r_rxId,      w_rxId;
  logic        r_rxRtr,     w_rxRtr;
  logic [3:0]  r_rxDlc,     w_rxDlc;
  logic        r_frameDone, w_frameDone;
  logic        r_stuffErr,  w_stuffErr;
  logic        r_formErr,   w_formErr;

  logic        w_inFrame;
  logic        w_tailStuff;
  logic        w_bitOk;
  logic [3:0]  w_newDlc;
  logic [6:0]  w_dataLast;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_WAIT_IDLE;
      r_bitCnt    <= 7'd0;
      r_idleCnt   <= 4'd0;
      r_lastBit   <= 1'b0;
      r_sameCnt   <= 3'd0;
      r_bitValid  <= 1'b0;
      r_bitOut    <= 1'b0;
      r_rxId      <= 11'd0;
      r_rxRtr     <= 1'b0;
      r_rxDlc     <= 4'd0;
      r_frameDone <= 1'b0;
      r_stuffErr  <= 1'b0;
      r_formErr   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bitCnt    <= w_bitCnt;
      r_idleCnt   <= w_idleCnt;
      r_lastBit   <= w_lastBit;
      r_sameCnt   <= w_sameCnt;
      r_bitValid  <= w_bitValid;
      r_bitOut    <= w_bitOut;
      r_rxId      <= w_rxId;
      r_rxRtr     <= w_rxRtr;
      r_rxDlc     <= w_rxDlc;
      r_frameDone <= w_frameDone;
      r_stuffErr  <= w_stuffErr;
      r_formErr   <= w_formErr;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_bitCnt    = r_bitCnt;
    w_idleCnt   = r_idleCnt;
    w_lastBit   = r_lastBit;
    w_sameCnt   = r_sameCnt;
    w_bitValid  = 1'b0;
    w_bitOut    = r_bitOut;
    w_rxId      = r_rxId;
    w_rxRtr     = r_rxRtr;
    w_rxDlc     = r_rxDlc;
    w_frameDone = 1'b0;
    w_stuffErr  = 1'b0;
    w_formErr   = 1'b0;
    w_bitOk     = 1'b0;
    w_newDlc    = {r_rxDlc[2:0], rxBit};
    w_dataLast  = r_rxDlc[3] ? 7'd63 : {1'b0, r_rxDlc[2:0] - 3'd1, 3'b111};
    w_inFrame   = (r_state == S_ARB) || (r_state == S_CTRL) ||
                  (r_state == S_DATA) || (r_state == S_CRC);
    // A stuff bit may trail the last CRC bit; it is consumed before the delimiter.
    w_tailStuff = (r_state == S_TAIL) && (r_bitCnt == 7'd0) && (r_sameCnt == c_stuffRun);

    if (sampleStrobe) begin
      if (w_inFrame || w_tailStuff) begin
        if (r_sameCnt == c_stuffRun) begin
          if (rxBit == r_lastBit) begin
            w_stuffErr = 1'b1;
          end else begin
            w_lastBit = rxBit;
            w_sameCnt = 3'd1;
          end
        end else begin
          if (rxBit == r_lastBit) begin
            w_sameCnt = r_sameCnt + 3'd1;
          end else begin
            w_lastBit = rxBit;
            w_sameCnt = 3'd1;
          end
          w_bitOk    = 1'b1;
          w_bitValid = 1'b1;
          w_bitOut   = rxBit;
        end
      end

      case (r_state)
        S_WAIT_IDLE: begin
          if (!rxBit) begin
            w_idleCnt = 4'd0;
          end else if (r_idleCnt == c_idleLast) begin
            w_idleCnt = 4'd0;
            w_state   = S_IDLE;
          end else begin
            w_idleCnt = r_idleCnt + 4'd1;
          end
        end
        S_IDLE: begin
          if (!rxBit) begin
            w_state   = S_ARB;
            w_bitCnt  = 7'd0;
            w_lastBit = 1'b0;
            w_sameCnt = 3'd1;
          end
        end
        S_ARB: begin
          if (w_bitOk) begin
            if (r_bitCnt < 7'd11) begin
              w_rxId   = {r_rxId[9:0], rxBit};
              w_bitCnt = r_bitCnt + 7'd1;
            end else begin
              w_rxRtr  = rxBit;
              w_bitCnt = 7'd0;
              w_state  = S_CTRL;
            end
          end
        end
        S_CTRL: begin
          if (w_bitOk) begin
            if (r_bitCnt == 7'd0 && rxBit) begin
              w_formErr = 1'b1;
            end else if (r_bitCnt >= 7'd2) begin
              w_rxDlc = w_newDlc;
            end
            if (r_bitCnt == 7'd5) begin
              w_bitCnt = 7'd0;
              w_state  = (r_rxRtr || w_newDlc == 4'd0) ? S_CRC : S_DATA;
            end else begin
              w_bitCnt = r_bitCnt + 7'd1;
            end
          end
        end
        S_DATA: begin
          if (w_bitOk) begin
            if (r_bitCnt == w_dataLast) begin
              w_bitCnt = 7'd0;
              w_state  = S_CRC;
            end else begin
              w_bitCnt = r_bitCnt + 7'd1;
            end
          end
        end
        S_CRC: begin
          if (w_bitOk) begin
            if (r_bitCnt == 7'd14) begin
              w_bitCnt = 7'd0;
              w_state  = S_TAIL;
            end else begin
              w_bitCnt = r_bitCnt + 7'd1;
            end
          end
        end
        S_TAIL: begin
          if (!w_tailStuff) begin
            // Bit 1 is the ACK slot, whose level is ignored.
            if (r_bitCnt != 7'd1 && !rxBit) begin
              w_formErr = 1'b1;
            end else if (r_bitCnt == 7'd9) begin
              w_frameDone = 1'b1;
              w_bitCnt    = 7'd0;
              w_state     = S_IDLE;
            end else begin
              w_bitCnt = r_bitCnt + 7'd1;
            end
          end
        end
        default: begin
          w_state   = S_WAIT_IDLE;
          w_idleCnt = 4'd0;
        end
      endcase

      if (w_stuffErr || w_formErr) begin
        w_state     = S_WAIT_IDLE;
        w_idleCnt   = 4'd0;
        w_bitCnt    = 7'd0;
        w_bitValid  = 1'b0;
        w_frameDone = 1'b0;
      end
    end
  end

  assign field       = r_state;
  assign override    = (r_state == S_TAIL) || (r_state == S_WAIT_IDLE);
  assign multiSelect = (r_state == S_ARB) && cfgMultiSample;
  assign bitValid    = r_bitValid;
  assign bitOut      = r_bitOut;
  assign rxId        = r_rxId;
  assign rxRtr       = r_rxRtr;
  assign rxDlc       = r_rxDlc;
  assign frameDone   = r_frameDone;
  assign stuffErr    = r_stuffErr;
  assign formErr     = r_formErr;

endmodule

`default_nettype wire

// File: tb/tb_can_rx_sequencer.sv
// ============================================================================
// Module   : tb_can_rx_sequencer
// Summary  : Self-checking bench for can_rx_sequencer using directed frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_rx_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sampleStrobe;
  logic        rxBit;
  logic        cfgMultiSample;
  logic        override;
  logic        multiSelect;
  logic        bitValid;
  logic        bitOut;
  logic [2:0]  field;
  logic [10:0] rxId;
  logic        rxRtr;
  logic [3:0]  rxDlc;
  logic        frameDone;
  logic        stuffErr;
  logic        formErr;

  can_rx_sequencer #(.IDLE_BITS(11)) dut (
    .clk(clk), .resetN(resetN), .sampleStrobe(sampleStrobe), .rxBit(rxBit),
    .cfgMultiSample(cfgMultiSample), .override(override), .multiSelect(multiSelect),
    .bitValid(bitValid), .bitOut(bitOut), .field(field), .rxId(rxId), .rxRtr(rxRtr),
    .rxDlc(rxDlc), .frameDone(frameDone), .stuffErr(stuffErr), .formErr(formErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [14:0] crc;
    logic        multi;
    int          period;
    int          expValid;
    int          expData;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   failures = 0;
  bit   rawQ[$];
  bit   txQ[$];
  bit   gotQ[$];
  int   tailStart;

  // Observed-event counters, written only by the monitor.
  int validCnt = 0, doneCnt = 0, stuffCnt = 0, formCnt = 0;
  int dataCyc = 0, crcCyc = 0, msErr = 0, msHigh = 0;

  always @(negedge clk) begin
    if (bitValid) begin
      validCnt++;
      gotQ.push_back(bitOut);
    end
    if (frameDone) doneCnt++;
    if (stuffErr) stuffCnt++;
    if (formErr) formCnt++;
    if (field == 3'd3) dataCyc++;
    if (field == 3'd4) crcCyc++;
    if (multiSelect) msHigh++;
    if (multiSelect !== ((field == 3'd1) && cfgMultiSample)) msErr++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input bit b, input int period);
    rxBit = b;
    sampleStrobe = 1'b1;
    @(negedge clk);
    sampleStrobe = 1'b0;
    for (int k = 1; k < period; k++) begin
      rxBit = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic sendOnes(input int n);
    for (int k = 0; k < n; k++) sendBit(1'b1, 1);
  endtask

  task automatic buildFrame(input logic [10:0] id, input logic rtr, input logic ide,
                            input logic [3:0] dlc, input logic [63:0] data,
                            input logic [14:0] crc);
    int nData;
    int run;
    bit last;
    rawQ.delete();
    txQ.delete();
    rawQ.push_back(1'b0);
    for (int i = 10; i >= 0; i--) rawQ.push_back(id[i]);
    rawQ.push_back(rtr);
    rawQ.push_back(ide);
    rawQ.push_back(1'b0);
    for (int i = 3; i >= 0; i--) rawQ.push_back(dlc[i]);
    nData = rtr ? 0 : ((dlc > 4'd8) ? 64 : 8 * int'(dlc));
    for (int i = 0; i < nData; i++) rawQ.push_back(data[63-i]);
    for (int i = 14; i >= 0; i--) rawQ.push_back(crc[i]);
    run  = 0;
    last = 1'b1;
    foreach (rawQ[i]) begin
      if (run == 5) begin
        txQ.push_back(~last);
        last = ~last;
        run  = 1;
      end
      txQ.push_back(rawQ[i]);
      if (rawQ[i] == last) run++;
      else begin
        last = rawQ[i];
        run  = 1;
      end
    end
    if (run == 5) txQ.push_back(~last);
    tailStart = txQ.size();
    txQ.push_back(1'b1);
    txQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) txQ.push_back(1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bV, bG, bD, bS, bF, bDat, bCrc, bMs, bMsH, mism;

    vecs[0] = '{11'h123, 1'b0, 4'd1,  64'hA500_0000_0000_0000, 15'h2B5C, 1'b0, 1, 41, 1};
    vecs[1] = '{11'h000, 1'b0, 4'd0,  64'h0,                   15'h0000, 1'b0, 3, 33, 0};
    vecs[2] = '{11'h7FF, 1'b1, 4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 15'h001F, 1'b1, 1, 33, 0};
    vecs[3] = '{11'h555, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 15'h4321, 1'b0, 2, 97, 1};
    vecs[4] = '{11'h0F0, 1'b0, 4'd2,  64'hFF00_0000_0000_0000, 15'h7FFF, 1'b1, 1, 49, 1};

    resetN = 1'b0;
    sampleStrobe = 1'b0;
    rxBit = 1'b1;
    cfgMultiSample = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_field", field, 3'd7);
    check("rst_override", override, 1'b1);
    check("rst_outputs", {multiSelect, bitValid, bitOut, frameDone, stuffErr, formErr}, 6'd0);
    check("rst_fields", {rxId, rxRtr, rxDlc}, 16'd0);
    resetN = 1'b1;
    @(negedge clk);

    // A dominant sample restarts the recessive count.
    bV = validCnt;
    sendOnes(10);
    sendBit(1'b0, 1);
    sendOnes(10);
    check("idle_after_21", field, 3'd7);
    sendOnes(1);
    check("idle_field", field, 3'd0);
    check("idle_override", override, 1'b0);
    check("idle_no_valid", validCnt - bV, 0);

    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      cfgMultiSample = vecs[v].multi;
      @(negedge clk);
      buildFrame(vecs[v].id, vecs[v].rtr, 1'b0, vecs[v].dlc, vecs[v].data, vecs[v].crc);
      bV = validCnt; bG = gotQ.size(); bD = doneCnt; bS = stuffCnt; bF = formCnt;
      bDat = dataCyc; bCrc = crcCyc; bMs = msErr; bMsH = msHigh;
      foreach (txQ[i]) sendBit(txQ[i], vecs[v].period);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_valid", v), validCnt - bV, vecs[v].expValid);
      mism = 0;
      for (int i = 1; i < rawQ.size(); i++)
        if (bG + i - 1 >= gotQ.size() || gotQ[bG+i-1] != rawQ[i]) mism++;
      check($sformatf("v%0d_bits", v), mism, 0);
      check($sformatf("v%0d_rxId", v), rxId, vecs[v].id);
      check($sformatf("v%0d_rxRtr", v), rxRtr, vecs[v].rtr);
      check($sformatf("v%0d_rxDlc", v), rxDlc, vecs[v].dlc);
      check($sformatf("v%0d_done", v), doneCnt - bD, 1);
      check($sformatf("v%0d_errs", v), (stuffCnt - bS) + (formCnt - bF), 0);
      check($sformatf("v%0d_field", v), field, 3'd0);
      check($sformatf("v%0d_data_seen", v), (dataCyc - bDat) != 0, vecs[v].expData);
      check($sformatf("v%0d_crc_seen", v), (crcCyc - bCrc) != 0, 1);
      check($sformatf("v%0d_msel", v), msErr - bMs, 0);
      check($sformatf("v%0d_msel_seen", v), (msHigh - bMsH) != 0, vecs[v].multi);
    end
    @(posedge clk);
    cfgMultiSample = 1'b0;
    @(negedge clk);

    // Sixth consecutive dominant sample counting SOF.
    bV = validCnt; bS = stuffCnt;
    sendBit(1'b0, 1);
    for (int i = 0; i < 5; i++) sendBit(1'b0, 1);
    repeat (2) @(negedge clk);
    check("stuff_err_count", stuffCnt - bS, 1);
    check("stuff_valid", validCnt - bV, 4);
    check("stuff_field", field, 3'd7);
    check("stuff_override", override, 1'b1);
    sendOnes(10);
    sendBit(1'b0, 1);
    check("stuff_no_early_sof", field, 3'd7);
    sendOnes(11);
    check("stuff_recover", field, 3'd0);

    // Dominant CRC delimiter.
    buildFrame(11'h123, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 15'h2B5C);
    txQ[tailStart] = 1'b0;
    bD = doneCnt; bF = formCnt;
    foreach (txQ[i]) sendBit(txQ[i], 1);
    repeat (2) @(negedge clk);
    check("delim_formErr", formCnt - bF, 1);
    check("delim_done", doneCnt - bD, 0);
    check("delim_field", field, 3'd7);
    sendOnes(11);
    check("delim_recover", field, 3'd0);

    // Extended-frame IDE bit is rejected.
    buildFrame(11'h3C3, 1'b0, 1'b1, 4'd1, 64'h0, 15'h1111);
    bV = validCnt; bF = formCnt; bD = doneCnt;
    foreach (txQ[i]) sendBit(txQ[i], 1);
    repeat (2) @(negedge clk);
    check("ide_formErr", formCnt - bF, 1);
    check("ide_valid", validCnt - bV, 12);
    check("ide_done", doneCnt - bD, 0);
    sendOnes(11);
    check("ide_recover", field, 3'd0);

    // Reset mid-frame aborts without pulses.
    buildFrame(11'h123, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 15'h2B5C);
    for (int i = 0; i < 20; i++) sendBit(txQ[i], 1);
    resetN = 1'b0;
    #1;
    bV = validCnt; bD = doneCnt; bS = stuffCnt; bF = formCnt;
    for (int i = 20; i < 25; i++) sendBit(txQ[i], 1);
    check("abort_field", field, 3'd7);
    check("abort_override", override, 1'b1);
    check("abort_rxId", rxId, 11'd0);
    check("abort_pulses", (validCnt - bV) + (doneCnt - bD) + (stuffCnt - bS) + (formCnt - bF), 0);
    resetN = 1'b1;
    @(negedge clk);
    sendOnes(11);
    bD = doneCnt;
    foreach (txQ[i]) sendBit(txQ[i], 1);
    repeat (2) @(negedge clk);
    check("after_abort_done", doneCnt - bD, 1);
    check("after_abort_rxId", rxId, 11'h123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
